// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port word RAM between instruction fetch and load/store.
// Round-robin grant on ties, one-cycle read latency, and per-requester response hold under backpressure.
module mem_arbiter #(
   parameter int AW = 30,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   // fetch request / response
   input  logic          i_req_valid,
   input  logic [AW-1:0] i_req_addr,
   output logic          i_req_ready,
   output logic          i_rsp_valid,
   output logic [DW-1:0] i_rsp_data,
   input  logic          i_rsp_ready,
   // data request / response
   input  logic          d_req_valid,
   input  logic          d_req_we,
   input  logic [AW-1:0] d_req_addr,
   input  logic [DW-1:0] d_req_wdata,
   output logic          d_req_ready,
   output logic          d_rsp_valid,
   output logic [DW-1:0] d_rsp_data,
   input  logic          d_rsp_ready,
   // RAM port
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   output logic          mem_we,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} src_e;

   src_e          last_q, last_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;

   logic          i_pend_q, i_pend_d;
   logic          i_hold_vld_q, i_hold_vld_d;
   logic [DW-1:0] i_hold_q, i_hold_d;
   logic          d_pend_q, d_pend_d;
   logic          d_hold_vld_q, d_hold_vld_d;
   logic [DW-1:0] d_hold_q, d_hold_d;

   logic i_elig, d_elig;
   logic gnt_i, gnt_d;

   // A reader is only eligible if its response slot will be free next cycle.
   assign i_elig = i_req_valid && (!i_rsp_valid || i_rsp_ready);
   assign d_elig = d_req_valid && (d_req_we || !d_rsp_valid || d_rsp_ready);

   // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (rst_n) begin
         if (i_elig && d_elig) begin
            if (last_q == SRC_D) gnt_i = 1'b1;
            else                 gnt_d = 1'b1;
         end else begin
            gnt_i = i_elig;
            gnt_d = d_elig;
         end
      end
   end

   assign i_req_ready = gnt_i;
   assign d_req_ready = gnt_d;

   always_comb begin
      mem_re   = gnt_i || (gnt_d && !d_req_we);
      mem_we   = gnt_d && d_req_we;
      mem_addr = addr_q;
      mem_din  = din_q;
      if (gnt_i) mem_addr = i_req_addr;
      else if (gnt_d) mem_addr = d_req_addr;
      if (gnt_i || gnt_d) mem_din = d_req_wdata;
   end

   assign i_rsp_valid = i_pend_q || i_hold_vld_q;
   assign i_rsp_data  = i_hold_vld_q ? i_hold_q : mem_dout;
   assign d_rsp_valid = d_pend_q || d_hold_vld_q;
   assign d_rsp_data  = d_hold_vld_q ? d_hold_q : mem_dout;

   always_comb begin
      last_d = last_q;
      if (gnt_d)      last_d = SRC_D;
      else if (gnt_i) last_d = SRC_I;
      addr_d = mem_addr;
      din_d  = mem_din;

      // RAM data is only valid in the cycle after the read, so capture it then if not consumed.
      i_pend_d     = gnt_i;
      i_hold_vld_d = i_hold_vld_q;
      i_hold_d     = i_hold_q;
      if (i_pend_q && !i_rsp_ready) begin
         i_hold_vld_d = 1'b1;
         i_hold_d     = mem_dout;
      end else if (i_rsp_ready) begin
         i_hold_vld_d = 1'b0;
      end

      d_pend_d     = gnt_d && !d_req_we;
      d_hold_vld_d = d_hold_vld_q;
      d_hold_d     = d_hold_q;
      if (d_pend_q && !d_rsp_ready) begin
         d_hold_vld_d = 1'b1;
         d_hold_d     = mem_dout;
      end else if (d_rsp_ready) begin
         d_hold_vld_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q       <= SRC_D;
         addr_q       <= '0;
         din_q        <= '0;
         i_pend_q     <= 1'b0;
         i_hold_vld_q <= 1'b0;
         d_pend_q     <= 1'b0;
         d_hold_vld_q <= 1'b0;
         // NOTE: hold data registers are cleared too, so nothing stale is ever visible after reset.
         i_hold_q     <= '0;
         d_hold_q     <= '0;
      end else begin
         last_q       <= last_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         i_pend_q     <= i_pend_d;
         i_hold_vld_q <= i_hold_vld_d;
         i_hold_q     <= i_hold_d;
         d_pend_q     <= d_pend_d;
         d_hold_vld_q <= d_hold_vld_d;
         d_hold_q     <= d_hold_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: request-level reference model with per-requester response queues.
module tb_mem_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready;
   logic [AW-1:0] i_req_addr;
   logic [DW-1:0] i_rsp_data;
   logic          d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_ready;
   logic [AW-1:0] d_req_addr;
   logic [DW-1:0] d_req_wdata, d_rsp_data;
   logic [AW-1:0] mem_addr;
   logic          mem_re, mem_we;
   logic [DW-1:0] mem_din, mem_dout;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
      .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_ready(i_rsp_ready),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_ready(d_rsp_ready),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM stand-in: registered read, and garbage on the output whenever no read happened.
   logic [DW-1:0] ram [64];
   logic [DW-1:0] init_img [64];
   bit ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int k = 0; k < 64; k++) ram[k] <= init_img[k];
         ram_loaded <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr[5:0]] <= mem_din;
      end
      if (mem_re) mem_dout <= ram[mem_addr[5:0]];
      else        mem_dout <= $urandom;
   end

   // Reference model state
   logic [DW-1:0] ref_mem [64];
   logic [DW-1:0] qi[$];
   logic [DW-1:0] qd[$];
   int            last_src;   // 0 = fetch granted last, 1 = data granted last
   bit            addr_known;
   logic [AW-1:0] last_addr;

   int n_checks = 0;
   int n_errors = 0;

   bit            acc_i, acc_d;
   logic          obs_ir, obs_dr, obs_we, obs_irv;
   logic [DW-1:0] obs_ird;
   int            we_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every presented response against the queue of expected words.
   always @(negedge clk) begin
      check("i_rsp_valid", {31'b0, i_rsp_valid}, {31'b0, qi.size() != 0});
      if (i_rsp_valid && qi.size() != 0) begin
         check("i_rsp_data", i_rsp_data, qi[0]);
         if (i_rsp_ready) void'(qi.pop_front());
      end
      check("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, qd.size() != 0});
      if (d_rsp_valid && qd.size() != 0) begin
         check("d_rsp_data", d_rsp_data, qd[0]);
         if (d_rsp_ready) void'(qd.pop_front());
      end
   end

   // One cycle: entered and left at posedge+1 with inputs already driven.
   task automatic tick();
      bit ei, ed, gi, gd;
      #1;
      ei = i_req_valid && (qi.size() == 0 || i_rsp_ready);
      ed = d_req_valid && (d_req_we || qd.size() == 0 || d_rsp_ready);
      gi = 1'b0;
      gd = 1'b0;
      if (ei && ed) begin
         if (last_src == 1) gi = 1'b1;
         else               gd = 1'b1;
      end else begin
         gi = ei;
         gd = ed;
      end
      @(negedge clk);
      #1;
      obs_ir  = i_req_ready;
      obs_dr  = d_req_ready;
      obs_we  = mem_we;
      obs_irv = i_rsp_valid;
      obs_ird = i_rsp_data;
      if (mem_we) we_cnt++;
      check("i_req_ready", {31'b0, i_req_ready}, {31'b0, gi});
      check("d_req_ready", {31'b0, d_req_ready}, {31'b0, gd});
      check("mem_re", {31'b0, mem_re}, {31'b0, gi || (gd && !d_req_we)});
      check("mem_we", {31'b0, mem_we}, {31'b0, gd && d_req_we});
      if (gi) check("mem_addr_fetch", {2'b0, mem_addr}, {2'b0, i_req_addr});
      if (gd) check("mem_addr_data", {2'b0, mem_addr}, {2'b0, d_req_addr});
      if (gd && d_req_we) check("mem_din", mem_din, d_req_wdata);
      if (!gi && !gd && addr_known) check("mem_addr_hold", {2'b0, mem_addr}, {2'b0, last_addr});
      acc_i = gi;
      acc_d = gd;
      if (gi) begin
         qi.push_back(ref_mem[i_req_addr[5:0]]);
         last_src   = 0;
         last_addr  = i_req_addr;
         addr_known = 1'b1;
      end
      if (gd) begin
         if (d_req_we) ref_mem[d_req_addr[5:0]] = d_req_wdata;
         else          qd.push_back(ref_mem[d_req_addr[5:0]]);
         last_src   = 1;
         last_addr  = d_req_addr;
         addr_known = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      d_rsp_ready = 1'b1;
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      for (int k = 0; k < 64; k++) begin
         init_img[k] = $urandom;
      end
      init_img[16] = 32'h0050_0093;
      init_img[4]  = 32'hDEAD_BEEF;
      for (int k = 0; k < 64; k++) ref_mem[k] = init_img[k];
      last_src   = 1;
      addr_known = 1'b0;
      last_addr  = '0;
      we_cnt     = 0;

      // Reset: requests present must not be granted
      rst_n       = 1'b0;
      i_req_valid = 1'b1;
      i_req_addr  = 30'd1;
      i_rsp_ready = 1'b1;
      d_req_valid = 1'b1;
      d_req_we    = 1'b1;
      d_req_addr  = 30'd2;
      d_req_wdata = 32'hA5A5_A5A5;
      d_rsp_ready = 1'b1;
      #12;
      check("reset_i_req_ready", {31'b0, i_req_ready}, 32'd0);
      check("reset_d_req_ready", {31'b0, d_req_ready}, 32'd0);
      check("reset_mem_re", {31'b0, mem_re}, 32'd0);
      check("reset_mem_we", {31'b0, mem_we}, 32'd0);
      check("reset_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
      check("reset_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      d_req_we    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention out of reset: grants alternate I, D, I, D ...
      i_req_valid = 1'b1;
      d_req_valid = 1'b1;
      d_req_we    = 1'b0;
      i_req_addr  = 30'($urandom_range(0, 31));
      d_req_addr  = 30'($urandom_range(0, 31));
      for (int k = 0; k < 8; k++) begin
         tick();
         check("contention_grant_i", {31'b0, obs_ir}, {31'b0, (k % 2) == 0});
         if (acc_i) i_req_addr = 30'($urandom_range(0, 31));
         if (acc_d) d_req_addr = 30'($urandom_range(0, 31));
      end
      idle(2);

      // Lone fetch of 0x10
      i_req_valid = 1'b1;
      i_req_addr  = 30'h10;
      tick();
      check("lone_fetch_ready", {31'b0, obs_ir}, 32'd1);
      i_req_valid = 1'b0;
      tick();
      check("lone_fetch_rsp", obs_ird, 32'h0050_0093);
      idle(1);

      // Backpressure: fetch of addr 4 held for three cycles while data reads proceed
      i_req_valid = 1'b1;
      i_req_addr  = 30'd4;
      tick();
      i_req_addr  = 30'd5;
      i_rsp_ready = 1'b0;
      d_req_valid = 1'b1;
      d_req_we    = 1'b0;
      for (int k = 0; k < 3; k++) begin
         d_req_addr = 30'($urandom_range(8, 31));
         tick();
         check("bp_i_req_ready", {31'b0, obs_ir}, 32'd0);
         check("bp_i_rsp_valid", {31'b0, obs_irv}, 32'd1);
         check("bp_i_rsp_data", obs_ird, 32'hDEAD_BEEF);
      end
      d_req_valid = 1'b0;
      i_rsp_ready = 1'b1;
      tick();
      check("bp_release_accept", {31'b0, obs_ir}, 32'd1);
      idle(2);

      // Write 0x12345678 to addr 7, then read it back
      we_cnt      = 0;
      d_req_valid = 1'b1;
      d_req_we    = 1'b1;
      d_req_addr  = 30'd7;
      d_req_wdata = 32'h1234_5678;
      tick();
      d_req_we    = 1'b0;
      d_req_wdata = 32'h0;
      tick();
      d_req_valid = 1'b0;
      tick();
      idle(2);
      check("write_we_cycles", we_cnt, 32'd1);
      check("write_readback_model", ref_mem[7], 32'h1234_5678);

      // Randomised traffic; requests held until accepted
      acc_i = 1'b0;
      acc_d = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (acc_i || !i_req_valid) begin
            i_req_valid = ($urandom_range(0, 3) != 0);
            i_req_addr  = 30'($urandom_range(0, 31));
         end
         if (acc_d || !d_req_valid) begin
            d_req_valid = ($urandom_range(0, 3) != 0);
            d_req_we    = ($urandom_range(0, 2) == 0);
            d_req_addr  = 30'($urandom_range(0, 31));
            d_req_wdata = $urandom;
         end
         i_rsp_ready = ($urandom_range(0, 2) != 0);
         d_rsp_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         if (acc_i) i_req_valid = 1'b0;
         if (acc_d) d_req_valid = 1'b0;
         i_rsp_ready = 1'b1;
         d_rsp_ready = 1'b1;
         tick();
      end
      idle(2);

      // Reset mid-flight: read accepted, reset while its response is valid
      i_req_valid = 1'b1;
      i_req_addr  = 30'd3;
      tick();
      i_req_valid = 1'b0;
      check("pre_reset_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd1);
      rst_n = 1'b0;
      qi.delete();
      qd.delete();
      last_src   = 1;
      addr_known = 1'b0;
      #1;
      check("mid_reset_i_rsp_valid", {31'b0, i_rsp_valid}, 32'd0);
      check("mid_reset_d_rsp_valid", {31'b0, d_rsp_valid}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);
      i_req_valid = 1'b1;
      i_req_addr  = 30'd9;
      d_req_valid = 1'b1;
      d_req_we    = 1'b0;
      d_req_addr  = 30'd10;
      tick();
      check("post_reset_tie_fetch", {31'b0, obs_ir}, 32'd1);
      i_req_valid = 1'b0;
      tick();
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port word RAM between the instruction-fetch path and the load/store path of the cpu. Each requester sees an independent valid/ready request channel and a valid/ready read-response channel. The block drives the RAM's address, read enable, write enable and write data directly. It sits between the program counter/decode front end, the future load/store unit, and the `ram` instance.

## Interface
- `AW`, default 30: word address width, the RAM address, `pc[31:2]`.
- `DW`, default 32: data width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_req_valid` in 1: fetch request present.
- `i_req_addr` in AW: fetch word address.
- `i_req_ready` out 1: fetch request accepted this cycle.
- `i_rsp_valid` out 1: fetch data valid.
- `i_rsp_data` out DW: fetch data.
- `i_rsp_ready` in 1: fetch consumer takes the data.
- `d_req_valid` in 1: data request present.
- `d_req_we` in 1: 1 means write, 0 means read.
- `d_req_addr` in AW: data word address.
- `d_req_wdata` in DW: write data.
- `d_req_ready` out 1: data request accepted this cycle.
- `d_rsp_valid` out 1: load data valid.
- `d_rsp_data` out DW: load data.
- `d_rsp_ready` in 1: load consumer takes the data.
- `mem_addr` out AW: RAM address.
- `mem_re` out 1: RAM read enable.
- `mem_we` out 1: RAM write enable.
- `mem_din` out DW: RAM write data.
- `mem_dout` in DW: RAM read data, registered, valid the cycle after `mem_re`.

## Operation
- **Eligibility**
  - A read requester X (fetch, or data with `we`=0) is eligible iff `X_req_valid` && (!`X_rsp_valid` || `X_rsp_ready`).
  - A data write is eligible iff `d_req_valid`.
- **Grant**
  - At most one grant per cycle, combinational.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one not granted most recently wins (round-robin on a `last` flag).
  - `last` updates only on a grant. Reset value of `last` = data, so fetch wins the first tie.
- **Handshake**
  - `X_req_ready` = grant to X. A request is accepted when valid && ready.
  - Requesters hold valid, address and data stable until accepted. The arbiter never retracts a grant within a cycle.
- **RAM drive on grant**
  - `mem_addr` is the granted address.
  - `mem_re` = granted read.
  - `mem_we` = granted data write.
  - `mem_din` = `d_req_wdata`.
- **RAM drive with no grant**
  - `mem_re` = `mem_we` = 0.
  - `mem_addr` and `mem_din` hold their last value. They are not required to be 0.
- **Writes** complete on acceptance and produce no response.
- **Read return path**
  - A per-requester pending bit is set on an accepted read.
  - In the following cycle, `X_rsp_valid` = 1 and `X_rsp_data` = `mem_dout` (bypass).
  - If `X_rsp_ready` = 0 in that cycle, `mem_dout` is captured into X's hold register. `X_rsp_valid` stays 1 with data from the hold register until `X_rsp_ready` = 1.
- **Ordering**: responses per requester are returned in request order, with at most one in flight plus one held per requester.

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - pending bits = 0, `i_rsp_valid` = `d_rsp_valid` = 0, `last` = data;
  - hold registers = 0, `mem_re` = `mem_we` = 0, `i_req_ready` = `d_req_ready` = 0.
- Reset asserted mid-operation drops pending reads and held data immediately. No response appears after release.
- Read latency: request accepted in cycle T gives `X_rsp_valid` in T+1.
- Throughput: one access per cycle total. A single requester with `rsp_ready` held at 1 gets one read per cycle.
- Back-to-back reads for the same requester are permitted when `X_rsp_ready` = 1 in the cycle its previous response is valid.
- Simultaneous accepted read for X and X's held response accepted: the held data leaves in that cycle and the new data appears next cycle. No loss and no duplication.
- A data write and a fetch read contending follow the round-robin rule. A write does not bypass arbitration.
- `mem_dout` is consumed only in the cycle after `mem_re`. RAM output in other cycles is ignored.

## Test plan
- **Lone fetch**: `i_req_valid` = 1 with addr 0x10 (RAM[0x10] = 0x00500093) and `i_rsp_ready` = 1.
  - `i_req_ready` = 1 in T.
  - `mem_re` = 1 with `mem_addr` = 0x10.
  - `i_rsp_valid` = 1 with data 0x00500093 in T+1.
- **Contention**: both requesters issue reads every cycle, both `rsp_ready` = 1, out of reset.
  - Grants alternate I, D, I, D.
  - Each response returns the correct word one cycle after its grant.
- **Backpressure**: fetch read of addr 4 (data 0xDEADBEEF), then `i_rsp_ready` = 0 for 3 cycles.
  - `i_rsp_valid` stays 1 with 0xDEADBEEF for all 3 cycles while the RAM reads other addresses for D.
  - `i_req_ready` = 0 throughout, even with `i_req_valid` = 1.
- **Write then read**: D writes 0x12345678 to addr 7, then reads addr 7.
  - The write produces no `d_rsp_valid`.
  - The read returns 0x12345678.
  - `mem_we` is high exactly 1 cycle.
- **Reset mid-flight**: a read is accepted and `rst_n` goes low in the next cycle.
  - All `rsp_valid` go 0 immediately.
  - After release, no response appears and the first tie goes to fetch.
